// File: rtl/relu_maxpool_unit_pkg.sv
// Shared constants for the ReLU + 2x2 max-pool datapath.
// Holds the float32 word width default, the positive-zero encoding and the
// sign bit index used by the ReLU stage.
package relu_maxpool_unit_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam logic [DATA_WIDTH_DEF-1:0] FP_ZERO = 32'h0000_0000;
  localparam int unsigned SIGN_BIT = 31;

endpackage : relu_maxpool_unit_pkg

// File: rtl/relu_maxpool_unit_fp_pos_max.sv
// fp_pos_max: combinational max of two non-negative float32 words.
// Ports:
//   a, b : post-ReLU operands (sign bit is zero)
//   y_c  : the larger operand
// For non-negative IEEE-754 values the magnitude bits order exactly like the
// value, so an unsigned compare of the low bits is sufficient. Equal operands
// are bit-identical, so the tie choice is irrelevant.
module fp_pos_max #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y_c
);

  always_comb begin
    y_c = b;
    if (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) y_c = a;
  end

endmodule : fp_pos_max

// File: rtl/relu_maxpool_unit.sv
// relu_maxpool_unit: streaming ReLU followed by 2x2 stride-2 max pooling of a
// row-major W x H float32 feature map.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   in_valid   : in_data holds one sample this cycle
//   in_data    : float32 sample, row-major order
//   out_valid  : one-cycle pulse qualifying out_data (1-cycle latency)
//   out_data   : pooled value, held while out_valid is low
//   frame_done : pulses with the last pooled output of a frame
module relu_maxpool_unit
  import relu_maxpool_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned W          = 28,
  parameter int unsigned H          = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

  // Reject geometries that cannot be tiled by 2x2 windows.
  if ((W % 2) != 0 || W < 2 || (H % 2) != 0 || H < 2) begin : g_bad_geom
    $error("relu_maxpool_unit: W and H must be even and at least 2");
  end
  if (DATA_WIDTH != SIGN_BIT + 1) begin : g_bad_width
    $error("relu_maxpool_unit: DATA_WIDTH must match the float32 sign bit");
  end

  localparam int unsigned CW = $clog2(W);
  localparam int unsigned RW = $clog2(H);
  localparam int unsigned BD = W / 2;
  localparam int unsigned IW = (BD > 1) ? $clog2(BD) : 1;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] pair;
  logic [DATA_WIDTH-1:0] row_buf [BD];

  logic [DATA_WIDTH-1:0] relu_c;
  logic [DATA_WIDTH-1:0] pair_max_c;
  logic [DATA_WIDTH-1:0] win_max_c;
  logic [IW-1:0]         buf_idx_c;
  logic                  last_col_c;
  logic                  last_row_c;

  // ReLU: anything with the sign bit set (incl. -0.0 and negative NaN) -> +0.0.
  always_comb begin
    relu_c = in_data;
    if (in_data[SIGN_BIT]) relu_c = DATA_WIDTH'(FP_ZERO);
  end

  always_comb begin
    buf_idx_c  = IW'(col >> 1);
    last_col_c = (col == CW'(W - 1));
    last_row_c = (row == RW'(H - 1));
  end

  // Horizontal pair max, then fold in the upper row's pair max.
  fp_pos_max #(.DATA_WIDTH(DATA_WIDTH)) u_pair_max (
    .a   (pair),
    .b   (relu_c),
    .y_c (pair_max_c)
  );

  fp_pos_max #(.DATA_WIDTH(DATA_WIDTH)) u_win_max (
    .a   (row_buf[buf_idx_c]),
    .b   (pair_max_c),
    .y_c (win_max_c)
  );

  // Row buffer: written on odd columns of even rows, read on odd rows.
  // Every entry is rewritten before use, so no reset is needed.
  always_ff @(posedge clk) begin
    if (in_valid && col[0] && !row[0]) row_buf[buf_idx_c] <= pair_max_c;
  end

  // Position counters, pair register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      pair       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!col[0]) begin
          pair <= relu_c;
        end else if (row[0]) begin
          out_data   <= win_max_c;
          out_valid  <= 1'b1;
          frame_done <= last_col_c && last_row_c;
        end
        if (last_col_c) begin
          col <= '0;
          row <= last_row_c ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule : relu_maxpool_unit

// File: doc/relu_maxpool_unit.md
RELU_MAXPOOL_UNIT -- requirements
Module: relu_maxpool_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: IEEE-754 single-precision word width of every sample.
REQ-002 Parameter W, default 28: width of the incoming convolution feature map in samples; SHALL be even.
REQ-003 Parameter H, default 28: height of the incoming feature map in rows; SHALL be even.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 in_valid  input  1: in_data carries one convolution result this cycle.
REQ-007 in_data  input  DATA_WIDTH: float32 convolution result, feature map in row-major order.
REQ-008 out_valid  output  1: one-cycle pulse qualifying out_data.
REQ-009 out_data  output  DATA_WIDTH: float32 pooled value, ReLU applied.
REQ-010 frame_done  output  1: one-cycle pulse on the last pooled output of a frame.

Function
REQ-011 ReLU: any accepted sample with sign bit 1, including -0.0 and negative NaN, SHALL be replaced by 0x00000000; otherwise passed unchanged.
REQ-012 Max compare on post-ReLU words SHALL be an unsigned integer compare of the 31 low bits; ties keep either value, since the values are bit-identical.
REQ-013 Column counter col (0..W-1) and row counter row (0..H-1) SHALL advance only on cycles with in_valid=1; col wraps to 0 and row increments; after (H-1, W-1) both wrap to 0.
REQ-014 Even col: the ReLU sample SHALL be held in pair register P.
REQ-015 Odd col, even row: max(P, sample) SHALL be written to row buffer entry col/2; the buffer depth SHALL be W/2.
REQ-016 Odd col, odd row: max(rowbuf[col/2], P, sample) SHALL be registered to out_data, and out_valid SHALL pulse on the next clock edge, giving 1-cycle latency.
REQ-017 Output rate: one pooled value per 2x2 window; (W/2)*(H/2) outputs per frame in row-major pooled order.
REQ-018 frame_done SHALL pulse in the same cycle as the out_valid of the window ending at (H-1, W-1).
REQ-019 Gaps in in_valid of any length SHALL NOT alter results; P and the row buffer hold their contents.
REQ-020 Back-to-back frames: the first sample of the next frame MAY arrive the cycle after the last sample of the previous frame, with no bubble required.
REQ-021 out_data SHALL hold its last value when out_valid=0.
REQ-022 There is no backpressure; the downstream consumer SHALL accept every out_valid pulse.

Reset
REQ-023 While reset=0: out_valid=0, out_data=0, frame_done=0, col=0, row=0, P=0.
REQ-024 Row buffer contents need not be reset; every entry is written in an even row before it is read.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first sample after release SHALL be treated as (0,0).

Structure
REQ-026 A shared package SHALL hold the DATA_WIDTH default, the FP_ZERO constant (0x00000000) and the SIGN_BIT index; W and H are module parameters.
REQ-027 One combinational sub-module, fp_pos_max, SHALL implement REQ-012 for two operands and be instantiated twice for the 3-way max.
REQ-028 The row buffer SHALL be a register array or inferred distributed RAM with one write and one read port.
REQ-029 An elaboration check SHALL fail if W or H is odd or less than 2.

Verification
REQ-030 W=H=28, all inputs 0x40800000 (4.0) -> 196 outputs all 0x40800000; frame_done only on the 196th.
REQ-031 W=H=4, all inputs 0xC0800000 (-4.0) -> 4 outputs of 0x00000000.
REQ-032 W=H=4, input k (k=0..15) as float(k) -> outputs 5.0, 7.0, 13.0, 15.0 (0x40A00000, 0x40E00000, 0x41500000, 0x41700000).
REQ-033 Repeat REQ-032 with in_valid low for 3 cycles between every sample -> identical outputs, each 1 cycle after the odd-row, odd-col beat.
REQ-034 W=H=4: assert reset after 9 samples, release, then send the full REQ-032 frame -> exactly 4 outputs matching REQ-032.
REQ-035 Two REQ-032 frames back-to-back with continuous in_valid -> 8 outputs, frame_done on the 4th and 8th.
